// File: rtl/rv64_decode_exec_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv64_decode_exec_mem_pkg
//  Brief    : Shared constants, encodings and helpers for the RV64I
//             decode/execute/memory datapath slice.
//  Revision : 1.0 - initial release
// ============================================================================
package rv64_decode_exec_mem_pkg;

   localparam int XLEN = 64;

   // Major opcodes recognised by the datapath
   localparam logic [6:0] c_opc_rtype  = 7'b0110011;
   localparam logic [6:0] c_opc_iarith = 7'b0010011;
   localparam logic [6:0] c_opc_load   = 7'b0000011;
   localparam logic [6:0] c_opc_store  = 7'b0100011;
   localparam logic [6:0] c_opc_branch = 7'b1100011;

   // Main-decoder to ALU-decoder operation class
   typedef enum logic [1:0] {
      ALUOP_ADD    = 2'b00,
      ALUOP_SUB    = 2'b01,
      ALUOP_RTYPE  = 2'b10,
      ALUOP_IARITH = 2'b11
   } aluop_e;

   // ALU operation select
   typedef enum logic [3:0] {
      ALU_AND = 4'b0000,
      ALU_OR  = 4'b0001,
      ALU_ADD = 4'b0010,
      ALU_SUB = 4'b0110
   } aluctl_e;

   // Control bundle produced by the main decoder
   typedef struct packed {
      logic   reg_write;
      logic   alu_src;
      logic   mem_read;
      logic   mem_write;
      logic   mem_to_reg;
      logic   branch;
      aluop_e alu_op;
   } ctrl_t;

   // Second-level ALU decode from the operation class and funct fields
   function automatic aluctl_e alu_control(input aluop_e op,
                                           input logic [2:0] funct3,
                                           input logic funct7_b5);
      aluctl_e ctl;
      ctl = ALU_ADD;
      case (op)
         ALUOP_ADD: ctl = ALU_ADD;
         ALUOP_SUB: ctl = ALU_SUB;
         ALUOP_RTYPE: begin
            case (funct3)
               3'b000:  ctl = funct7_b5 ? ALU_SUB : ALU_ADD;
               3'b111:  ctl = ALU_AND;
               3'b110:  ctl = ALU_OR;
               default: ctl = ALU_ADD;
            endcase
         end
         ALUOP_IARITH: begin
            case (funct3)
               3'b111:  ctl = ALU_AND;
               3'b110:  ctl = ALU_OR;
               default: ctl = ALU_ADD;
            endcase
         end
         default: ctl = ALU_ADD;
      endcase
      return ctl;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rv64_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : rv64_regfile
//  Brief    : 32 x 64-bit register file, two combinational read ports, one
//             synchronous write port, x0 hardwired to zero, synchronous reset.
//  Revision : 1.0 - initial release
// ============================================================================
module rv64_regfile
   import rv64_decode_exec_mem_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic [4:0]      rs1_addr_i,
   input  logic [4:0]      rs2_addr_i,
   output logic [XLEN-1:0] rs1_data_o,
   output logic [XLEN-1:0] rs2_data_o,
   input  logic            we_i,
   input  logic [4:0]      rd_addr_i,
   input  logic [XLEN-1:0] rd_data_i,
   output logic [XLEN-1:0] a0_o
);

   logic [XLEN-1:0] regs_q [32];

   // Reset clears every register; otherwise commit the write unless it targets x0
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= '0;
         end
      end else if (we_i && (rd_addr_i != 5'd0)) begin
         regs_q[rd_addr_i] <= rd_data_i;
      end
   end

   // Reads see the pre-edge contents; x0 is forced to zero
   always_comb begin
      rs1_data_o = (rs1_addr_i == 5'd0) ? '0 : regs_q[rs1_addr_i];
      rs2_data_o = (rs2_addr_i == 5'd0) ? '0 : regs_q[rs2_addr_i];
      a0_o       = regs_q[10];
   end

endmodule
`default_nettype wire

// File: rtl/rv64_decode_exec_mem.sv
`default_nettype none
// ============================================================================
//  Module   : rv64_decode_exec_mem
//  Brief    : Single-cycle RV64I slice: decode, register read, ALU, data
//             memory, write-back and next-PC selection.
//             Optional macro DMEM_CLEAR_EN: reset also zeroes data memory.
//  Revision : 1.0 - initial release
// ============================================================================
module rv64_decode_exec_mem
   import rv64_decode_exec_mem_pkg::*;
#(
   parameter int DMEM_WORDS = 128
)(
   input  logic            clk,
   input  logic            reset,
   input  logic [31:0]     inst,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] pc_plus4,
   output logic [XLEN-1:0] next_pc,
   output logic [XLEN-1:0] dbg_a0
);

   localparam int c_aw = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   ctrl_t           ctrl;
   aluctl_e         alu_ctl;
   logic [XLEN-1:0] imm;
   logic [XLEN-1:0] imm_b;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic [XLEN-1:0] alu_b;
   logic [XLEN-1:0] alu_result;
   logic            zero;
   logic            taken;
   logic [c_aw-1:0] mem_addr;
   logic [XLEN-1:0] mem_rdata;
   logic [XLEN-1:0] wb_data;

   assign opcode = inst[6:0];
   assign funct3 = inst[14:12];
   assign funct7 = inst[31:25];

   // Main decoder: unsupported opcode/funct combinations leave every control low
   always_comb begin
      ctrl = '0;
      case (opcode)
         c_opc_rtype: begin
            if ((funct7 == 7'b0000000 && (funct3 == 3'b000 || funct3 == 3'b111 ||
                                          funct3 == 3'b110)) ||
                (funct7 == 7'b0100000 && funct3 == 3'b000)) begin
               ctrl.reg_write = 1'b1;
               ctrl.alu_op    = ALUOP_RTYPE;
            end
         end
         c_opc_iarith: begin
            if (funct3 == 3'b000 || funct3 == 3'b111 || funct3 == 3'b110) begin
               ctrl.reg_write = 1'b1;
               ctrl.alu_src   = 1'b1;
               ctrl.alu_op    = ALUOP_IARITH;
            end
         end
         c_opc_load: begin
            if (funct3 == 3'b011) begin
               ctrl.reg_write  = 1'b1;
               ctrl.alu_src    = 1'b1;
               ctrl.mem_read   = 1'b1;
               ctrl.mem_to_reg = 1'b1;
               ctrl.alu_op     = ALUOP_ADD;
            end
         end
         c_opc_store: begin
            if (funct3 == 3'b011) begin
               ctrl.alu_src   = 1'b1;
               ctrl.mem_write = 1'b1;
               ctrl.alu_op    = ALUOP_ADD;
            end
         end
         c_opc_branch: begin
            if (funct3 == 3'b000 || funct3 == 3'b001) begin
               ctrl.branch = 1'b1;
               ctrl.alu_op = ALUOP_SUB;
            end
         end
         default: ctrl = '0;
      endcase
   end

   // Immediate generation: S for stores, B for branches, I for everything else
   always_comb begin
      imm_b = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      case (opcode)
         c_opc_store:  imm = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
         c_opc_branch: imm = imm_b;
         default:      imm = {{(XLEN-12){inst[31]}}, inst[31:20]};
      endcase
   end

   rv64_regfile u_regfile (
      .clk        (clk),
      .reset      (reset),
      .rs1_addr_i (inst[19:15]),
      .rs2_addr_i (inst[24:20]),
      .rs1_data_o (rs1_data),
      .rs2_data_o (rs2_data),
      .we_i       (ctrl.reg_write),
      .rd_addr_i  (inst[11:7]),
      .rd_data_i  (wb_data),
      .a0_o       (dbg_a0)
   );

   // ALU: wrapping 64-bit arithmetic, zero flag drives branch resolution
   always_comb begin
      alu_ctl = alu_control(ctrl.alu_op, funct3, funct7[5]);
      alu_b   = ctrl.alu_src ? imm : rs2_data;
      case (alu_ctl)
         ALU_AND: alu_result = rs1_data & alu_b;
         ALU_OR:  alu_result = rs1_data | alu_b;
         ALU_SUB: alu_result = rs1_data - alu_b;
         default: alu_result = rs1_data + alu_b;
      endcase
      zero = (alu_result == '0);
   end

   // Doubleword index: byte offset dropped, upper address bits wrap
   assign mem_addr = alu_result[c_aw+2:3];

`ifdef DMEM_CLEAR_EN
   logic [XLEN-1:0] mem_q [DMEM_WORDS];

   // Reset wipes data memory; otherwise commit stores
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DMEM_WORDS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (ctrl.mem_write) begin
         mem_q[mem_addr] <= rs2_data;
      end
   end
`else
   logic [XLEN-1:0] mem_q [DMEM_WORDS] = '{default: '0};

   // Stores commit outside reset; contents survive a reset
   always_ff @(posedge clk) begin
      if (!reset && ctrl.mem_write) begin
         mem_q[mem_addr] <= rs2_data;
      end
   end
`endif

   // Load path, write-back select and next-PC selection
   always_comb begin
      mem_rdata = ctrl.mem_read ? mem_q[mem_addr] : '0;
      wb_data   = ctrl.mem_to_reg ? mem_rdata : alu_result;
      taken     = ctrl.branch && (funct3[0] ? !zero : zero);
      next_pc   = taken ? (pc + imm_b) : pc_plus4;
   end

endmodule
`default_nettype wire

// File: tb/tb_rv64_decode_exec_mem.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rv64_decode_exec_mem
//  Brief    : Directed self-checking bench for rv64_decode_exec_mem.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rv64_decode_exec_mem;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] inst;
   logic [63:0] pc;
   logic [63:0] pc_plus4;
   logic [63:0] next_pc;
   logic [63:0] dbg_a0;

   int n_checks = 0;
   int n_errors = 0;

   rv64_decode_exec_mem #(.DMEM_WORDS(128)) dut (
      .clk      (clk),
      .reset    (reset),
      .inst     (inst),
      .pc       (pc),
      .pc_plus4 (pc_plus4),
      .next_pc  (next_pc),
      .dbg_a0   (dbg_a0)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%016h expected=0x%016h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                         input int rd, input logic [6:0] op);
      logic [11:0] i12 = imm[11:0];
      return {i12, rs1[4:0], f3[2:0], rd[4:0], op};
   endfunction

   function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                         input int f3, input int rd);
      return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
      logic [11:0] i12 = imm[11:0];
      return {i12[11:5], rs2[4:0], rs1[4:0], 3'b011, i12[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1,
                                         input int f3);
      logic [12:0] b = imm[12:0];
      return {b[12], b[10:5], rs2[4:0], rs1[4:0], f3[2:0], b[4:1], b[11], 7'b1100011};
   endfunction

   // Present one instruction, check next_pc mid-cycle, then let it commit
   task automatic step(input string tag, input logic [31:0] i, input logic [63:0] p,
                       input logic [63:0] exp_npc);
      inst     = i;
      pc       = p;
      pc_plus4 = p + 64'd4;
      @(negedge clk);
      check_eq({tag, "_npc"}, next_pc, exp_npc);
      @(posedge clk);
      #1;
   endtask

   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_LD = 7'b0000011;

   initial begin
      reset    = 1'b1;
      inst     = 32'h0;
      pc       = 64'h0;
      pc_plus4 = 64'h4;
      @(posedge clk);
      #1;
      // Instruction presented during reset must not commit
      inst = enc_i(9, 0, 0, 10, OP_I);
      @(posedge clk);
      #1;
      check_eq("reset_a0", dbg_a0, 64'h0);
      reset = 1'b0;

      step("addi5", enc_i(5, 0, 0, 10, OP_I), 64'h0, 64'h4);
      check_eq("addi5_a0", dbg_a0, 64'd5);

      step("addi_m3", enc_i(-3, 0, 0, 11, OP_I), 64'h4, 64'h8);
      step("add", enc_r(0, 11, 10, 0, 10), 64'h8, 64'hC);
      check_eq("add_a0", dbg_a0, 64'd2);
      step("sub", enc_r(32, 10, 11, 0, 10), 64'hC, 64'h10);
      check_eq("sub_a0", dbg_a0, 64'hFFFF_FFFF_FFFF_FFFB);

      // Logic ops: x12 = 0xF0, x13 = 0x3C
      step("li12", enc_i(12'h0F0, 0, 0, 12, OP_I), 64'h10, 64'h14);
      step("li13", enc_i(12'h03C, 0, 0, 13, OP_I), 64'h14, 64'h18);
      step("ori", enc_i(12'h00F, 12, 6, 10, OP_I), 64'h18, 64'h1C);
      check_eq("ori_a0", dbg_a0, 64'hFF);
      step("and", enc_r(0, 13, 12, 7, 10), 64'h1C, 64'h20);
      check_eq("and_a0", dbg_a0, 64'h30);
      step("or", enc_r(0, 13, 12, 6, 10), 64'h20, 64'h24);
      check_eq("or_a0", dbg_a0, 64'hFC);
      step("andi_neg", enc_i(-1, 11, 7, 10, OP_I), 64'h24, 64'h28);
      check_eq("andi_neg_a0", dbg_a0, 64'hFFFF_FFFF_FFFF_FFFD);

      // Build x5 = 0x1234 (0x7FF*2 + 0x236), x6 = 16
      step("li5a", enc_i(12'h7FF, 0, 0, 5, OP_I), 64'h28, 64'h2C);
      step("dbl5", enc_r(0, 5, 5, 0, 5), 64'h2C, 64'h30);
      step("li5b", enc_i(12'h236, 5, 0, 5, OP_I), 64'h30, 64'h34);
      step("li6", enc_i(16, 0, 0, 6, OP_I), 64'h34, 64'h38);
      step("sd", enc_s(8, 5, 6), 64'h38, 64'h3C);
      step("ld8", enc_i(8, 6, 3, 10, OP_LD), 64'h3C, 64'h40);
      check_eq("ld8_a0", dbg_a0, 64'h1234);
      step("clr10", enc_i(0, 0, 0, 10, OP_I), 64'h40, 64'h44);
      step("ld15", enc_i(15, 6, 3, 10, OP_LD), 64'h44, 64'h48);
      check_eq("ld15_a0", dbg_a0, 64'h1234);
      step("clr10b", enc_i(0, 0, 0, 10, OP_I), 64'h48, 64'h4C);
      // 1048 = 1024 + 24: wraps onto doubleword 3
      step("ldwrap", enc_i(1048, 0, 3, 10, OP_LD), 64'h4C, 64'h50);
      check_eq("ldwrap_a0", dbg_a0, 64'h1234);

      // Branches at pc 0x40 (x10 = 0x1234)
      step("beq_t", enc_b(-8, 0, 0, 0), 64'h40, 64'h38);
      step("bne_nt", enc_b(12, 0, 0, 1), 64'h40, 64'h44);
      step("bne_t", enc_b(12, 0, 10, 1), 64'h40, 64'h4C);
      step("beq_nt", enc_b(-8, 0, 10, 0), 64'h40, 64'h44);
      check_eq("branch_nowb_a0", dbg_a0, 64'h1234);

      // x0 stays zero; unsupported encodings change nothing
      step("addi_x0", enc_i(7, 0, 0, 0, OP_I), 64'h50, 64'h54);
      step("op7f", enc_i(33, 0, 0, 10, 7'h7F), 64'h54, 64'h58);
      check_eq("op7f_a0", dbg_a0, 64'h1234);
      step("sll_nop", enc_r(0, 13, 12, 1, 10), 64'h58, 64'h5C);
      check_eq("sll_nop_a0", dbg_a0, 64'h1234);
      step("rd_x0", enc_r(0, 0, 0, 0, 10), 64'h5C, 64'h60);
      check_eq("x0_zero_a0", dbg_a0, 64'h0);

      // Store 0xAB at doubleword 0, then reset with a write in flight
      step("li7", enc_i(12'h0AB, 0, 0, 7, OP_I), 64'h60, 64'h64);
      step("sd0", enc_s(0, 7, 0), 64'h64, 64'h68);
      step("li10", enc_i(1, 0, 0, 10, OP_I), 64'h68, 64'h6C);
      check_eq("pre_rst_a0", dbg_a0, 64'h1);
      reset = 1'b1;
      step("rst_inflight", enc_i(99, 0, 0, 10, OP_I), 64'h6C, 64'h70);
      reset = 1'b0;
      check_eq("rst_a0", dbg_a0, 64'h0);
      step("ld0", enc_i(0, 0, 3, 10, OP_LD), 64'h70, 64'h74);
`ifdef DMEM_CLEAR_EN
      check_eq("ld_after_rst", dbg_a0, 64'h0);
`else
      check_eq("ld_after_rst", dbg_a0, 64'hAB);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
